// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: EX passes through in the same cycle; LU results go through a FIFO into idle port cycles.
// Latency: EX 0 cycles, LU at least 1 cycle. Backpressure: lu_rdy_o drops when the FIFO is full, and ex_stall_o holds EX on a forced drain.

module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_vld,
   input  logic [WIDTH-1:0]           push_dat,
   input  logic                       pop_vld,
   output logic [WIDTH-1:0]           head_dat,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push  = push_vld & (count != FULL_CNT);
   assign do_pop   = pop_vld & (count != '0);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

module wb_port_arbiter #(
   parameter int W_RD       = 5,
   parameter int WORD       = 32,
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_v_i,
   input  logic            ex_wb_i,
   input  logic [W_RD-1:0] ex_rd_num_i,
   input  logic [WORD-1:0] ex_rd_data_i,
   output logic            ex_stall_o,
   input  logic            lu_v_i,
   input  logic [W_RD-1:0] lu_rd_num_i,
   input  logic [WORD-1:0] lu_rd_data_i,
   output logic            lu_rdy_o,
   output logic            wb_o,
   output logic [W_RD-1:0] wbr_num_o,
   output logic [WORD-1:0] wb_data_o
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   typedef struct packed {
      logic [W_RD-1:0] rd;
      logic [WORD-1:0] dat;
   } lu_ent_t;

   lu_ent_t         push_ent;
   lu_ent_t         head_ent;
   logic [CW-1:0]   count;
   logic [SW-1:0]   starve;
   logic            ex_req;
   logic            fifo_ne;
   logic            force_drain;
   logic            grant_ex;
   logic            grant_lu;
   logic            push_vld;

   assign ex_req      = ex_v_i & ex_wb_i;
   assign fifo_ne     = (count != '0);
   assign force_drain = fifo_ne & (starve == STARVE_LIM);

   assign grant_lu   = ~rst & fifo_ne & (force_drain | ~ex_req);
   assign grant_ex   = ~rst & ex_req & ~force_drain;
   assign ex_stall_o = ~rst & force_drain & ex_req;

   // No pop-through: readiness depends only on the registered count.
   assign lu_rdy_o = ~rst & (count != FULL_CNT);

   // Writes to r0 complete the handshake but are dropped rather than buffered.
   assign push_vld = lu_v_i & lu_rdy_o & (lu_rd_num_i != '0);
   assign push_ent = '{rd: lu_rd_num_i, dat: lu_rd_data_i};

   sync_fifo #(
      .WIDTH ($bits(lu_ent_t)),
      .DEPTH (DEPTH)
   ) u_lu_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_vld (push_vld),
      .push_dat (push_ent),
      .pop_vld  (grant_lu),
      .head_dat (head_ent),
      .count    (count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         starve <= '0;
      end else if (grant_lu || !fifo_ne) begin
         starve <= '0;
      end else if (grant_ex && (starve != STARVE_LIM)) begin
         starve <= starve + SW'(1);
      end
   end

   always_comb begin
      wb_o      = 1'b0;
      wbr_num_o = '0;
      wb_data_o = '0;
      if (grant_lu) begin
         wb_o      = 1'b1;
         wbr_num_o = head_ent.rd;
         wb_data_o = head_ent.dat;
      end else if (grant_ex) begin
         wb_o      = 1'b1;
         wbr_num_o = ex_rd_num_i;
         wb_data_o = ex_rd_data_i;
      end
   end
endmodule
